// File: rtl/led_pwm_pkg.sv
// Shared register offsets, parameter defaults and address decode for the LED PWM PIO.
package led_pwm_pkg;

    localparam int unsigned DEF_NUM_CH  = 8;
    localparam int unsigned DEF_PWM_W   = 8;
    localparam int unsigned DEF_PRESC_W = 16;
    localparam int unsigned DEF_ADDR_W  = 4;

    localparam int unsigned REG_DATA      = 0;
    localparam int unsigned REG_MODE      = 1;
    localparam int unsigned REG_PRESCALE  = 2;
    localparam int unsigned REG_PWM_CNT   = 3;
    localparam int unsigned REG_DUTY_BASE = 4;

    typedef enum logic [2:0] {
        SelNone,
        SelData,
        SelMode,
        SelPrescale,
        SelPwmCnt,
        SelDuty
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input int unsigned addr, input int unsigned num_ch);
        reg_sel_e sel;
        sel = SelNone;
        if (addr == REG_DATA) begin
            sel = SelData;
        end else if (addr == REG_MODE) begin
            sel = SelMode;
        end else if (addr == REG_PRESCALE) begin
            sel = SelPrescale;
        end else if (addr == REG_PWM_CNT) begin
            sel = SelPwmCnt;
        end else if (addr >= REG_DUTY_BASE && addr < REG_DUTY_BASE + num_ch) begin
            sel = SelDuty;
        end
        return sel;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: duty compare, optional wrap-synchronised duty shadow, output flop.
// Shadow duty is enabled by defining LED_PWM_SYNC_UPDATE_EN.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int unsigned PWM_W = DEF_PWM_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             data,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic [PWM_W-1:0] duty,
    input  logic             load,
    output logic             led
);

    logic [PWM_W-1:0] duty_eff;
    logic             led_next;

`ifdef LED_PWM_SYNC_UPDATE_EN
    logic [PWM_W-1:0] duty_shadow;

    // Duty only changes at the period boundary so a period never mixes two duties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_shadow <= '0;
        end else if (load) begin
            duty_shadow <= duty;
        end
    end

    assign duty_eff = duty_shadow;
`else
    logic load_unused;

    assign load_unused = load;
    assign duty_eff    = duty;
`endif

    assign led_next = mode ? (pwm_cnt < duty_eff) : data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led <= 1'b0;
        end else begin
            led <= led_next;
        end
    end

endmodule

// File: rtl/led_pwm_pio.sv
// Avalon-MM LED PIO with per-channel PWM; optional LED_PWM_SYNC_UPDATE_EN latches duties
// at each PWM period wrap.
module led_pwm_pio
    import led_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH  = DEF_NUM_CH,
    parameter int unsigned PWM_W   = DEF_PWM_W,
    parameter int unsigned PRESC_W = DEF_PRESC_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic [NUM_CH-1:0] led_out,
    output logic              period_tick
);

    logic [NUM_CH-1:0]  data_reg;
    logic [NUM_CH-1:0]  mode_reg;
    logic [PRESC_W-1:0] prescale_reg;
    logic [PRESC_W-1:0] presc_cnt;
    logic [PWM_W-1:0]   pwm_cnt;
    logic [PWM_W-1:0]   duty_reg [NUM_CH];

    reg_sel_e           addr_sel;
    logic [ADDR_W-1:0]  duty_idx;
    logic [31:0]        rd_mux;
    logic               tick;
    logic               wrap;
    logic               wdata_unused;

    assign addr_sel     = decode_addr(32'(avs_address), NUM_CH);
    assign duty_idx     = avs_address - ADDR_W'(REG_DUTY_BASE);
    assign wdata_unused = ^avs_writedata;

    // Register file
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg     <= '0;
            mode_reg     <= '0;
            prescale_reg <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_reg[i] <= '0;
            end
        end else if (avs_write) begin
            case (addr_sel)
                SelData:     data_reg     <= avs_writedata[NUM_CH-1:0];
                SelMode:     mode_reg     <= avs_writedata[NUM_CH-1:0];
                SelPrescale: prescale_reg <= avs_writedata[PRESC_W-1:0];
                SelDuty: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (duty_idx == ADDR_W'(i)) begin
                            duty_reg[i] <= avs_writedata[PWM_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr_sel)
            SelData:     rd_mux = 32'(data_reg);
            SelMode:     rd_mux = 32'(mode_reg);
            SelPrescale: rd_mux = 32'(prescale_reg);
            SelPwmCnt:   rd_mux = 32'(pwm_cnt);
            SelDuty: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (duty_idx == ADDR_W'(i)) begin
                        rd_mux = 32'(duty_reg[i]);
                    end
                end
            end
            default:     rd_mux = '0;
        endcase
    end

    // Sampling the current registers gives the pre-write value on a same-cycle read/write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avs_readdata <= '0;
        end else begin
            avs_readdata <= avs_read ? rd_mux : '0;
        end
    end

    assign tick = (presc_cnt == prescale_reg);
    assign wrap = tick && (pwm_cnt == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            period_tick <= 1'b0;
        end else begin
            if ((avs_write && addr_sel == SelPrescale) || tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + PRESC_W'(1);
            end
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_W'(1);
            end
            period_tick <= wrap;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_W (PWM_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .mode    (mode_reg[i]),
            .data    (data_reg[i]),
            .pwm_cnt (pwm_cnt),
            .duty    (duty_reg[i]),
            .load    (wrap),
            .led     (led_out[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_pio.sv
// Directed self-checking bench for led_pwm_pio (default parameters).
`timescale 1ns/1ps
module tb_led_pwm_pio;

    localparam int unsigned NUM_CH  = 8;
    localparam int unsigned PWM_W   = 8;
    localparam int unsigned PRESC_W = 16;
    localparam int unsigned ADDR_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;
    logic [NUM_CH-1:0] led_out;
    logic              period_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pwm_pio #(
        .NUM_CH  (NUM_CH),
        .PWM_W   (PWM_W),
        .PRESC_W (PRESC_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .led_out       (led_out),
        .period_tick   (period_tick)
    );

    // Bus tasks are entered and left on a falling edge.
    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset         = 1'b1;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (led_out !== '0) begin
            errors++;
            $display("FAIL reset_led: got %h expected 00", led_out);
        end
        checks++;
        if (period_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_period_tick: got %b expected 0", period_tick);
        end
        checks++;
        if (avs_readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_readdata: got %h expected 0", avs_readdata);
        end
        reset = 1'b0;
        bus_read(4'd3, rd);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL reset_pwm_cnt_first: got %h expected 0", rd);
        end
        bus_read(4'd3, rd);
        checks++;
        if (rd !== 32'd1) begin
            errors++;
            $display("FAIL reset_pwm_cnt_resume: got %h expected 1", rd);
        end
        for (int a = 0; a < 12; a++) begin
            if (a != 3) begin
                bus_read(ADDR_W'(a), rd);
                checks++;
                if (rd !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_reg_%0d: got %h expected 0", a, rd);
                end
            end
        end
    endtask

    task automatic test_pwm();
        logic [7:0] duties [3];
        int         exp_high [3];
        int         high;
        int         ticks;
        int         gap;
        bit         found;
        duties   = '{8'd64, 8'd0, 8'd255};
        exp_high = '{64, 0, 255};
        bus_write(4'd2, 32'd0);
        bus_write(4'd1, 32'h01);
        for (int k = 0; k < 3; k++) begin
            bus_write(4'd4, 32'(duties[k]));
            repeat (300) @(negedge clk);
            high  = 0;
            ticks = 0;
            for (int c = 0; c < 512; c++) begin
                @(negedge clk);
                if (led_out[0]) high++;
                if (period_tick) ticks++;
            end
            checks++;
            if (high != 2 * exp_high[k]) begin
                errors++;
                $display("FAIL pwm_high_duty%0d: got %0d expected %0d", duties[k], high,
                         2 * exp_high[k]);
            end
            checks++;
            if (ticks != 2) begin
                errors++;
                $display("FAIL pwm_ticks_duty%0d: got %0d expected 2", duties[k], ticks);
            end
        end
        checks++;
        if (led_out[7:1] !== 7'h0) begin
            errors++;
            $display("FAIL pwm_other_channels: got %h expected 00", led_out[7:1]);
        end
        found = 1'b0;
        for (int c = 0; c < 600 && !found; c++) begin
            @(negedge clk);
            if (period_tick) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL pwm_tick_timeout: got none expected a pulse within 600 cycles");
        end
        gap   = 0;
        found = 1'b0;
        for (int c = 0; c < 600 && !found; c++) begin
            @(negedge clk);
            gap++;
            if (period_tick) found = 1'b1;
        end
        checks++;
        if (gap != 256) begin
            errors++;
            $display("FAIL pwm_tick_spacing: got %0d expected 256", gap);
        end
    endtask

    task automatic test_static();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        bus_write(4'd2, 32'd3);
        bus_write(4'd1, 32'h00);
        bus_write(4'd0, 32'hA5);
        checks++;
        if (led_out !== 8'h00) begin
            errors++;
            $display("FAIL static_led_early: got %h expected 00", led_out);
        end
        @(negedge clk);
        checks++;
        if (led_out !== 8'hA5) begin
            errors++;
            $display("FAIL static_led: got %h expected a5", led_out);
        end
        bus_read(4'd3, a);
        repeat (3) @(negedge clk);
        bus_read(4'd3, b);
        checks++;
        if (b !== {24'h0, a[7:0] + 8'd1}) begin
            errors++;
            $display("FAIL presc3_step4: got %h expected %h", b, {24'h0, a[7:0] + 8'd1});
        end
        repeat (7) @(negedge clk);
        bus_read(4'd3, c);
        checks++;
        if (c !== {24'h0, b[7:0] + 8'd2}) begin
            errors++;
            $display("FAIL presc3_step8: got %h expected %h", c, {24'h0, b[7:0] + 8'd2});
        end
    endtask

    task automatic test_map();
        logic [31:0] rd;
        logic [31:0] cnt;
        bus_read(4'd15, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL map_read15: got %h expected 0", rd);
        end
        bus_read(4'd12, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL map_read12: got %h expected 0", rd);
        end
        bus_write(4'd15, 32'hFFFF_FFFF);
        bus_read(4'd0, rd);
        checks++;
        if (rd !== 32'hA5) begin
            errors++;
            $display("FAIL map_w15_data: got %h expected a5", rd);
        end
        bus_read(4'd2, rd);
        checks++;
        if (rd !== 32'd3) begin
            errors++;
            $display("FAIL map_w15_prescale: got %h expected 3", rd);
        end
        bus_read(4'd15, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL map_w15_read15: got %h expected 0", rd);
        end
        // Freeze the counter so a write to PWM_CNT would be visible.
        bus_write(4'd2, 32'hFFFF);
        bus_read(4'd3, cnt);
        bus_write(4'd3, {24'h0, ~cnt[7:0]});
        bus_read(4'd3, rd);
        checks++;
        if (rd !== cnt) begin
            errors++;
            $display("FAIL map_pwm_cnt_ro: got %h expected %h", rd, cnt);
        end
        bus_write(4'd0, 32'hFFFF_FF3C);
        bus_read(4'd0, rd);
        checks++;
        if (rd !== 32'h3C) begin
            errors++;
            $display("FAIL map_data_upper: got %h expected 3c", rd);
        end
        bus_write(4'd11, 32'hFFFF_FF12);
        bus_read(4'd11, rd);
        checks++;
        if (rd !== 32'h12) begin
            errors++;
            $display("FAIL map_duty7_upper: got %h expected 12", rd);
        end
        bus_write(4'd2, 32'hABCD_1234);
        bus_read(4'd2, rd);
        checks++;
        if (rd !== 32'h1234) begin
            errors++;
            $display("FAIL map_prescale_upper: got %h expected 1234", rd);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] rd;
        bus_write(4'd0, 32'h00);
        avs_address   = 4'd0;
        avs_writedata = 32'hFF;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_read  = 1'b0;
        avs_write = 1'b0;
        checks++;
        if (avs_readdata !== 32'h00) begin
            errors++;
            $display("FAIL same_cycle_old: got %h expected 00", avs_readdata);
        end
        bus_read(4'd0, rd);
        checks++;
        if (rd !== 32'hFF) begin
            errors++;
            $display("FAIL same_cycle_new: got %h expected ff", rd);
        end
    endtask

    task automatic test_duty_update();
        int high1;
        int high2;
        int exp1;
        bit found;
`ifdef LED_PWM_SYNC_UPDATE_EN
        exp1 = 32;
`else
        exp1 = 131;
`endif
        bus_write(4'd2, 32'd0);
        bus_write(4'd0, 32'h00);
        bus_write(4'd1, 32'h04);
        bus_write(4'd6, 32'd32);
        found = 1'b0;
        for (int c = 0; c < 600 && !found; c++) begin
            @(negedge clk);
            if (period_tick) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL duty_tick_timeout: got none expected a pulse within 600 cycles");
        end
        high1 = 0;
        high2 = 0;
        for (int s = 1; s <= 512; s++) begin
            @(negedge clk);
            if (led_out[2]) begin
                if (s <= 256) high1++;
                else high2++;
            end
            if (s == 100) begin
                avs_address   = 4'd6;
                avs_writedata = 32'd200;
                avs_write     = 1'b1;
            end else if (s == 101) begin
                avs_write = 1'b0;
            end
        end
        checks++;
        if (high1 != exp1) begin
            errors++;
            $display("FAIL duty_change_period: got %0d expected %0d", high1, exp1);
        end
        checks++;
        if (high2 != 200) begin
            errors++;
            $display("FAIL duty_next_period: got %0d expected 200", high2);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        bus_write(4'd2, 32'd0);
        bus_write(4'd1, 32'hFF);
        for (int i = 0; i < 8; i++) begin
            bus_write(ADDR_W'(4 + i), 32'h80);
        end
        repeat (40) @(negedge clk);
        bus_read(4'd1, rd);
        checks++;
        if (rd !== 32'hFF) begin
            errors++;
            $display("FAIL mid_mode_before: got %h expected ff", rd);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (led_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_led: got %h expected 00", led_out);
        end
        checks++;
        if (avs_readdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_readdata: got %h expected 0", avs_readdata);
        end
        checks++;
        if (period_tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_period_tick: got %b expected 0", period_tick);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 12; a++) begin
            bus_read(ADDR_W'(a), rd);
            checks++;
            if (rd !== 32'h0 && a != 3) begin
                errors++;
                $display("FAIL mid_reset_reg_%0d: got %h expected 0", a, rd);
            end else if (a == 3 && rd !== 32'd3) begin
                errors++;
                $display("FAIL mid_reset_pwm_cnt: got %h expected 3", rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pwm();
        test_static();
        test_map();
        test_same_cycle();
        test_duty_update();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pwm_pio.md
LED_PWM_PIO -- requirements
Module: led_pwm_pio

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of LED channels (1..12).
REQ-002 SHALL have parameter PWM_W, default 8: PWM counter and duty width (2..16).
REQ-003 SHALL have parameter PRESC_W, default 16: prescaler width (1..32).
REQ-004 SHALL have parameter ADDR_W, default 4: word-address width; NUM_CH+4 <= 2**ADDR_W.
REQ-005 SHALL have port clk  input  1  sole clock.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port avs_address  input  ADDR_W  Avalon-MM word address.
REQ-008 SHALL have port avs_read  input  1  read strobe.
REQ-009 SHALL have port avs_write  input  1  write strobe.
REQ-010 SHALL have port avs_writedata  input  32  write data.
REQ-011 SHALL have port avs_readdata  output  32  read data.
REQ-012 SHALL have port led_out  output  NUM_CH  registered LED drive.
REQ-013 SHALL have port period_tick  output  1  one-cycle pulse on PWM counter wrap.

Function
REQ-014 SHALL implement the register map: 0 DATA[NUM_CH-1:0] RW; 1 MODE[NUM_CH-1:0] RW (1=PWM, 0=static); 2 PRESCALE[PRESC_W-1:0] RW; 3 PWM_CNT RO; 4+i DUTY[i][PWM_W-1:0] RW.
REQ-015 SHALL have no waitrequest; writes take effect on the strobe edge; reads have fixed latency 1.
REQ-016 SHALL return zero for unused upper bits and for unmapped addresses; SHALL ignore writes to unmapped addresses and to PWM_CNT.
REQ-017 SHALL, on a same-cycle read and write to one address, return the pre-write value.
REQ-018 SHALL count presc_cnt 0..PRESCALE, asserting tick when presc_cnt==PRESCALE and then returning to 0; PRESCALE=0 gives a tick every cycle.
REQ-019 SHALL clear presc_cnt to 0 on any PRESCALE write.
REQ-020 SHALL increment pwm_cnt (PWM_W bits) on each tick, wrapping from all-ones to 0.
REQ-021 SHALL pulse period_tick for the cycle in which pwm_cnt wraps to 0.
REQ-022 SHALL compute channel i as MODE[i] ? (pwm_cnt < duty_eff[i]) : DATA[i], and register it into led_out[i] one cycle later.
REQ-023 SHALL give constant off at duty 0, and on for 2**PWM_W-1 of 2**PWM_W steps at duty all-ones.
REQ-024 SHALL make a MODE or DATA change visible on led_out two cycles after the write strobe.

Reset
REQ-025 SHALL clear DATA, MODE, PRESCALE, all DUTY, shadow duties, presc_cnt, pwm_cnt, led_out, period_tick and avs_readdata to 0 immediately on reset assertion.
REQ-026 SHALL resume counting on the first clk edge after reset deasserts.

Configuration
REQ-027 SHALL, with LED_PWM_SYNC_UPDATE_EN defined, take duty_eff[i] from a shadow register loaded from DUTY[i] only on the cycle pwm_cnt wraps to 0, giving glitch-free duty changes.
REQ-028 SHALL, without LED_PWM_SYNC_UPDATE_EN, set duty_eff[i]=DUTY[i] directly, so writes affect the comparison the cycle after the write.

Structure
REQ-029 SHALL place the register offsets (DATA, MODE, PRESCALE, PWM_CNT, DUTY_BASE) and parameter defaults in the shared package led_pwm_pkg.
REQ-030 SHALL instantiate one sub-module, led_pwm_channel, per channel (compare, optional shadow, output flop).

Verification
REQ-031 Reset mid-PWM, with MODE=0xFF and DUTY=0x80 -> led_out=0 and all registers read 0 the same cycle.
REQ-032 PRESCALE=0, MODE[0]=1, DUTY[0]=64 -> led_out[0] high 64 of every 256 cycles; period_tick every 256 cycles.
REQ-033 PRESCALE=3, MODE=0, DATA=0xA5 -> led_out=0xA5 two cycles after the write; PWM_CNT advances once per 4 cycles.
REQ-034 Read address 3 (PWM_CNT) and address 15 -> live count and 0 respectively; a write to 15 has no effect.
REQ-035 With LED_PWM_SYNC_UPDATE_EN, write DUTY[2] 32->200 mid-period -> high time changes only from the next wrap; without the macro -> changes within the current period.
REQ-036 Same-cycle read and write of DATA (0x00->0xFF) -> readdata=0x00; the next read returns 0xFF.
